// File: rtl/jtag_tap_chain.sv
// jtag_tap_chain
//   Daisy chain of NUM_TAPS IEEE 1149.1 TAPs that share one TAP state machine.
//   Everything runs on clk_i. TCK is oversampled through a 2-flop synchroniser
//   plus a history flop, so a TCK edge is acted on at the 3rd clk_i edge after
//   it happens. TMS/TDI are sampled on that same clk_i edge.
//   TAP 0 drives tdo_o; tdi_i enters TAP NUM_TAPS-1.
//
// Parameters
//   NUM_TAPS    number of TAPs in the chain (1..8)
//   IR_LEN      instruction register length per TAP (2..8)
//   IDCODE_BASE IDCODE of TAP k is IDCODE_BASE + (k << 12), bit 0 forced to 1
//
// Ports
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   tck_i       JTAG TCK (asynchronous, oversampled)
//   tms_i       JTAG TMS
//   tdi_i       JTAG TDI
//   tdo_o       JTAG TDO, updated on TCK fall
//   tdo_oen_o   high while shifting (Shift-DR / Shift-IR)
//   tap_state_o current TAP state
//   tlr_o       high in Test-Logic-Reset
//
// Optional feature (macro JTAG_USER_REG_EN)
//   Adds a 32-bit USER data register per TAP (instruction 2) and the ports
//   user_data_o [NUM_TAPS*32] / user_update_o [NUM_TAPS]. Without the macro,
//   instruction 2 behaves as BYPASS.
module jtag_tap_chain #(
  parameter int unsigned NUM_TAPS    = 2,
  parameter int unsigned IR_LEN      = 5,
  parameter logic [31:0] IDCODE_BASE = 32'h1DEAD3FF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     tck_i,
  input  logic                     tms_i,
  input  logic                     tdi_i,
  output logic                     tdo_o,
  output logic                     tdo_oen_o,
  output logic [3:0]               tap_state_o,
  output logic                     tlr_o
`ifdef JTAG_USER_REG_EN
  ,
  output logic [NUM_TAPS*32-1:0]   user_data_o,
  output logic [NUM_TAPS-1:0]      user_update_o
`endif
);

  localparam logic [3:0] ST_TLR    = 4'hF;
  localparam logic [3:0] ST_RTI    = 4'hC;
  localparam logic [3:0] ST_SEL_DR = 4'h7;
  localparam logic [3:0] ST_CAP_DR = 4'h6;
  localparam logic [3:0] ST_SH_DR  = 4'h2;
  localparam logic [3:0] ST_EX1_DR = 4'h1;
  localparam logic [3:0] ST_PAU_DR = 4'h3;
  localparam logic [3:0] ST_EX2_DR = 4'h0;
  localparam logic [3:0] ST_UPD_DR = 4'h5;
  localparam logic [3:0] ST_SEL_IR = 4'h4;
  localparam logic [3:0] ST_CAP_IR = 4'hE;
  localparam logic [3:0] ST_SH_IR  = 4'hA;
  localparam logic [3:0] ST_EX1_IR = 4'h9;
  localparam logic [3:0] ST_PAU_IR = 4'hB;
  localparam logic [3:0] ST_EX2_IR = 4'h8;
  localparam logic [3:0] ST_UPD_IR = 4'hD;

  // Also the Capture-IR pattern {0...,01}.
  localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(1);
`ifdef JTAG_USER_REG_EN
  localparam logic [IR_LEN-1:0] IR_USER   = IR_LEN'(2);
`endif

  logic              tck_s1_q, tck_s1_d;
  logic              tck_s2_q, tck_s2_d;
  logic              tck_hist_q, tck_hist_d;
  logic [3:0]        state_q, state_d;
  logic [IR_LEN-1:0] ir_q    [NUM_TAPS];
  logic [IR_LEN-1:0] ir_d    [NUM_TAPS];
  logic [IR_LEN-1:0] ir_sr_q [NUM_TAPS];
  logic [IR_LEN-1:0] ir_sr_d [NUM_TAPS];
  logic [31:0]       dr_sr_q [NUM_TAPS];
  logic [31:0]       dr_sr_d [NUM_TAPS];
  logic              tdo_q, tdo_d;
  logic              oen_q, oen_d;
`ifdef JTAG_USER_REG_EN
  logic [31:0]       user_data_q [NUM_TAPS];
  logic [31:0]       user_data_d [NUM_TAPS];
  logic [NUM_TAPS-1:0] user_upd_q, user_upd_d;
`endif

  logic                tck_rise, tck_fall;
  logic [NUM_TAPS:0]   ir_chain, dr_chain;
  logic [NUM_TAPS-1:0] sel_id, sel_user;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    case (s)
      ST_TLR:    return tms ? ST_TLR    : ST_RTI;
      ST_RTI:    return tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: return tms ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: return tms ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  return tms ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: return tms ? ST_UPD_DR : ST_PAU_DR;
      ST_PAU_DR: return tms ? ST_EX2_DR : ST_PAU_DR;
      ST_EX2_DR: return tms ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: return tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: return tms ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: return tms ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  return tms ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: return tms ? ST_UPD_IR : ST_PAU_IR;
      ST_PAU_IR: return tms ? ST_EX2_IR : ST_PAU_IR;
      ST_EX2_IR: return tms ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: return tms ? ST_SEL_DR : ST_RTI;
      default:   return ST_TLR;
    endcase
  endfunction

  function automatic logic [31:0] idcode_of(input int unsigned k);
    return (IDCODE_BASE + (k << 12)) | 32'h1;
  endfunction

  assign tck_rise = tck_s2_q & ~tck_hist_q;
  assign tck_fall = ~tck_s2_q & tck_hist_q;

  // Serial input of TAP k is entry k+1; the top entry is tdi_i.
  always_comb begin
    ir_chain = '0;
    dr_chain = '0;
    sel_id   = '0;
    sel_user = '0;
    for (int unsigned k = 0; k < NUM_TAPS; k++) begin
      ir_chain[k] = ir_sr_q[k][0];
      dr_chain[k] = dr_sr_q[k][0];
      sel_id[k]   = (ir_q[k] == IR_IDCODE);
`ifdef JTAG_USER_REG_EN
      sel_user[k] = (ir_q[k] == IR_USER);
`endif
    end
    ir_chain[NUM_TAPS] = tdi_i;
    dr_chain[NUM_TAPS] = tdi_i;
  end

  always_comb begin
    tck_s1_d   = tck_i;
    tck_s2_d   = tck_s1_q;
    tck_hist_d = tck_s2_q;
    state_d    = state_q;
    ir_d       = ir_q;
    ir_sr_d    = ir_sr_q;
    dr_sr_d    = dr_sr_q;
    tdo_d      = tdo_q;
    oen_d      = oen_q;
`ifdef JTAG_USER_REG_EN
    user_data_d = user_data_q;
    user_upd_d  = '0;
`endif
    if (tck_rise) begin
      state_d = tap_next(state_q, tms_i);
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        case (state_q)
          ST_CAP_IR: ir_sr_d[k] = IR_IDCODE;
          ST_SH_IR:  ir_sr_d[k] = {ir_chain[k+1], ir_sr_q[k][IR_LEN-1:1]};
          ST_CAP_DR: begin
            dr_sr_d[k] = '0;
            if (sel_id[k]) dr_sr_d[k] = idcode_of(k);
`ifdef JTAG_USER_REG_EN
            if (sel_user[k]) dr_sr_d[k] = user_data_q[k];
`endif
          end
          ST_SH_DR: begin
            // BYPASS is a 1-bit register living in bit 0.
            if (sel_id[k] || sel_user[k])
              dr_sr_d[k] = {dr_chain[k+1], dr_sr_q[k][31:1]};
            else
              dr_sr_d[k][0] = dr_chain[k+1];
          end
          default: ;
        endcase
        if (state_d == ST_TLR) ir_d[k] = IR_IDCODE;
      end
    end
    if (tck_fall) begin
      oen_d = (state_q == ST_SH_DR) || (state_q == ST_SH_IR);
      if (state_q == ST_SH_DR)      tdo_d = dr_sr_q[0][0];
      else if (state_q == ST_SH_IR) tdo_d = ir_sr_q[0][0];
      if (state_q == ST_UPD_IR) ir_d = ir_sr_q;
`ifdef JTAG_USER_REG_EN
      if (state_q == ST_UPD_DR) begin
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
          if (sel_user[k]) begin
            user_data_d[k] = dr_sr_q[k];
            user_upd_d[k]  = 1'b1;
          end
        end
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    // Synchroniser is left out of reset so a TCK level held across reset
    // does not look like a fresh edge afterwards.
    tck_s1_q   <= tck_s1_d;
    tck_s2_q   <= tck_s2_d;
    tck_hist_q <= tck_hist_d;
    if (rst_i) begin
      state_q <= ST_TLR;
      tdo_q   <= 1'b0;
      oen_q   <= 1'b0;
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        ir_q[k]    <= IR_IDCODE;
        ir_sr_q[k] <= '0;
        dr_sr_q[k] <= '0;
`ifdef JTAG_USER_REG_EN
        user_data_q[k] <= '0;
`endif
      end
`ifdef JTAG_USER_REG_EN
      user_upd_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      tdo_q   <= tdo_d;
      oen_q   <= oen_d;
      ir_q    <= ir_d;
      ir_sr_q <= ir_sr_d;
      dr_sr_q <= dr_sr_d;
`ifdef JTAG_USER_REG_EN
      user_data_q <= user_data_d;
      user_upd_q  <= user_upd_d;
`endif
    end
  end

  assign tdo_o       = tdo_q;
  assign tdo_oen_o   = oen_q;
  assign tap_state_o = state_q;
  assign tlr_o       = (state_q == ST_TLR);

`ifdef JTAG_USER_REG_EN
  always_comb begin
    user_data_o = '0;
    for (int unsigned k = 0; k < NUM_TAPS; k++) user_data_o[k*32 +: 32] = user_data_q[k];
  end
  assign user_update_o = user_upd_q;
`endif

endmodule

// File: tb/tb_jtag_tap_chain.sv
`timescale 1ns/1ps
module tb_jtag_tap_chain;
  localparam int          NT  = 2;
  localparam int          IRL = 5;
  localparam logic [31:0] IDB = 32'h1DEAD3FF;

  // TAP state codes as they appear on tap_state_o
  localparam int TLR = 15, RTI = 12, SELDR = 7, CAPDR = 6, SHDR = 2, EX1DR = 1,
                 PAUDR = 3, EX2DR = 0, UPDDR = 5, SELIR = 4, CAPIR = 14, SHIR = 10,
                 EX1IR = 9, PAUIR = 11, EX2IR = 8, UPDIR = 13;

  logic clk = 0, rst = 0, tck = 0, tms = 0, tdi = 0;
  logic tdo, oen, tlr;
  logic [3:0] st;
`ifdef JTAG_USER_REG_EN
  logic [NT*32-1:0] user_data;
  logic [NT-1:0]    user_update;
`endif

  jtag_tap_chain #(.NUM_TAPS(NT), .IR_LEN(IRL), .IDCODE_BASE(IDB)) dut (
    .clk_i(clk), .rst_i(rst), .tck_i(tck), .tms_i(tms), .tdi_i(tdi),
    .tdo_o(tdo), .tdo_oen_o(oen), .tap_state_o(st), .tlr_o(tlr)
`ifdef JTAG_USER_REG_EN
    , .user_data_o(user_data), .user_update_o(user_update)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit settled = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          nxt[16][2];
  int          m_state;
  bit          m_tdo, m_oen;
  logic [7:0]  m_ir[NT];
  bit          dq[$];
  bit          iq[$];
  logic [31:0] m_user[NT];
  int          exp_pulses[NT];
  int          got_pulses[NT];

  task automatic tr(input int s, input int n0, input int n1);
    nxt[s][0] = n0;
    nxt[s][1] = n1;
  endtask

  function automatic logic [31:0] id_of(input int k);
    return (IDB + 32'(k * 4096)) | 32'h1;
  endfunction

  function automatic bit is_long(input int k);
`ifdef JTAG_USER_REG_EN
    if (m_ir[k] == 8'd2) return 1'b1;
`endif
    return m_ir[k] == 8'd1;
  endfunction

  task automatic model_reset();
    m_state = TLR; m_tdo = 0; m_oen = 0;
    dq.delete(); iq.delete();
    for (int k = 0; k < NT; k++) begin m_ir[k] = 8'd1; m_user[k] = '0; end
  endtask

  task automatic model_rise(input bit t, input bit d);
    logic [31:0] w;
    int len;
    case (m_state)
      CAPDR: begin
        dq.delete();
        for (int k = 0; k < NT; k++) begin
          w = '0; len = 1;
          if (m_ir[k] == 8'd1) begin w = id_of(k); len = 32; end
`ifdef JTAG_USER_REG_EN
          if (m_ir[k] == 8'd2) begin w = m_user[k]; len = 32; end
`endif
          for (int b = 0; b < len; b++) dq.push_back(w[b]);
        end
      end
      SHDR: begin void'(dq.pop_front()); dq.push_back(d); end
      CAPIR: begin
        iq.delete();
        for (int k = 0; k < NT; k++)
          for (int b = 0; b < IRL; b++) iq.push_back(b == 0);
      end
      SHIR: begin void'(iq.pop_front()); iq.push_back(d); end
      default: ;
    endcase
    m_state = nxt[m_state][t];
    if (m_state == TLR) for (int k = 0; k < NT; k++) m_ir[k] = 8'd1;
  endtask

  task automatic model_fall();
    int off;
    if (m_state == UPDIR)
      for (int k = 0; k < NT; k++) begin
        m_ir[k] = '0;
        for (int b = 0; b < IRL; b++) m_ir[k][b] = iq[k*IRL + b];
      end
`ifdef JTAG_USER_REG_EN
    if (m_state == UPDDR) begin
      off = 0;
      for (int k = 0; k < NT; k++) begin
        if (m_ir[k] == 8'd2) begin
          for (int b = 0; b < 32; b++) m_user[k][b] = dq[off + b];
          exp_pulses[k]++;
        end
        off += is_long(k) ? 32 : 1;
      end
    end
`else
    off = 0;
`endif
    if (m_state == SHDR)      begin m_tdo = dq[0]; m_oen = 1; end
    else if (m_state == SHIR) begin m_tdo = iq[0]; m_oen = 1; end
    else m_oen = 0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (settled) begin
      check("tap_state", 64'(st), 64'(m_state));
      check("tlr", 64'(tlr), 64'(m_state == TLR));
      check("tdo", 64'(tdo), 64'(m_tdo));
      check("tdo_oen", 64'(oen), 64'(m_oen));
`ifdef JTAG_USER_REG_EN
      for (int k = 0; k < NT; k++) check("user_data", 64'(user_data[k*32 +: 32]), 64'(m_user[k]));
`endif
    end
  end

`ifdef JTAG_USER_REG_EN
  always @(negedge clk)
    for (int k = 0; k < NT; k++) if (user_update[k] === 1'b1) got_pulses[k]++;
`endif

  // ---------------- stimulus ----------------
  task automatic phase(input logic lvl);
    settled = 0;
    tck = lvl;
    if (lvl) model_rise(tms, tdi); else model_fall();
    repeat (3) @(posedge clk);
    #1 settled = 1;
    repeat (3) @(posedge clk);
    #1 settled = 0;
  endtask

  task automatic cyc(input bit t, input bit d, output bit b);
    tms = t; tdi = d;
    phase(1'b1);
    phase(1'b0);
    b = tdo;
  endtask

  task automatic do_reset(input bit with_rise);
    settled = 0;
    if (with_rise) tck = 1;
    rst = 1;
    repeat (4) @(posedge clk);
    #1 rst = 0;
    model_reset();
    check("rst_state", 64'(st), 64'hF);
    check("rst_tlr", 64'(tlr), 64'h1);
    check("rst_tdo", 64'(tdo), 64'h0);
    check("rst_oen", 64'(oen), 64'h0);
    if (with_rise) phase(1'b0);
    else begin repeat (3) @(posedge clk); #1; end
  endtask

  // From RTI: scan n bits through DR (ir=0) or IR (ir=1), finish in RTI.
  task automatic scan(input bit ir, input int n, input logic [63:0] din, output logic [63:0] dout);
    bit b;
    cyc(1, 0, b);
    if (ir) cyc(1, 0, b);
    cyc(0, 0, b);
    cyc(0, 0, b);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = b;
      cyc(i == n - 1, din[i], b);
    end
    cyc(1, 0, b);
    cyc(0, 0, b);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    bit b;
    tr(TLR, RTI, TLR);     tr(RTI, RTI, SELDR);   tr(SELDR, CAPDR, SELIR);
    tr(CAPDR, SHDR, EX1DR); tr(SHDR, SHDR, EX1DR); tr(EX1DR, PAUDR, UPDDR);
    tr(PAUDR, PAUDR, EX2DR); tr(EX2DR, SHDR, UPDDR); tr(UPDDR, RTI, SELDR);
    tr(SELIR, CAPIR, TLR); tr(CAPIR, SHIR, EX1IR); tr(SHIR, SHIR, EX1IR);
    tr(EX1IR, PAUIR, UPDIR); tr(PAUIR, PAUIR, EX2IR); tr(EX2IR, SHIR, UPDIR);
    tr(UPDIR, RTI, SELDR);
    for (int k = 0; k < NT; k++) begin exp_pulses[k] = 0; got_pulses[k] = 0; end

    repeat (3) @(posedge clk);
    #1 do_reset(0);

    // IDCODE readout of both TAPs
    cyc(0, 0, b);
    scan(0, 64, 64'h0, r);
    check("idcode_chain", r, {32'h1DEAE3FF, 32'h1DEAD3FF});

    // Capture-IR pattern, then BYPASS in both TAPs
    scan(1, 10, 64'h3FF, r);
    check("capture_ir", r, 64'h021);
    scan(0, 10, 64'h0A5, r);
    check("bypass_delay", r, 64'h294);

    // Five TMS=1 rises from Shift-DR reach TLR and restore IDCODE
    cyc(1, 0, b); cyc(0, 0, b); cyc(0, 0, b);
    for (int i = 0; i < 5; i++) cyc(1, 0, b);
    check("tms5_state", 64'(st), 64'hF);
    check("tms5_tlr", 64'(tlr), 64'h1);
    cyc(0, 0, b);
    scan(0, 64, 64'h0, r);
    check("idcode_after_tlr", r, {32'h1DEAE3FF, 32'h1DEAD3FF});

    // Reset mid-shift, coincident with a TCK rise
    cyc(1, 0, b); cyc(0, 0, b); cyc(0, 0, b);
    for (int i = 0; i < 10; i++) cyc(0, 1, b);
    tms = 0;
    do_reset(1);
    cyc(0, 0, b);
    scan(0, 64, 64'h0, r);
    check("idcode_after_rst", r, {32'h1DEAE3FF, 32'h1DEAD3FF});

    // TAP0 = instruction 2, TAP1 = BYPASS
    scan(1, 10, 64'h3E2, r);
`ifdef JTAG_USER_REG_EN
    scan(0, 33, {31'h0, 1'b0, 32'hCAFEF00D}, r);
    check("user_data0", 64'(user_data[31:0]), 64'hCAFEF00D);
    check("user_pulse0", 64'(got_pulses[0]), 64'h1);
    check("user_pulse1", 64'(got_pulses[1]), 64'h0);
    scan(0, 33, 64'h0, r);
    check("user_readback", r, 64'h0_CAFEF00D);
`else
    scan(0, 10, 64'h0A5, r);
    check("instr2_bypass", r, 64'h294);
`endif

    // Randomised TMS/TDI with occasional resets, checked by the model
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset($urandom_range(0, 1) == 1);
      else cyc($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), b);
    end

`ifdef JTAG_USER_REG_EN
    for (int k = 0; k < NT; k++) check("user_pulse_count", 64'(got_pulses[k]), 64'(exp_pulses[k]));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
